uart_secure_rx: RTL

//  Far-end receiver for the encrypted UART link (stream as driven on serial_tx_out).

---
 rtl/uart_secure_rx_pkg.sv | 25 ++
 rtl/uart_secure_rx_if.sv | 21 ++
 rtl/uart_rx_fifo.sv | 54 +++++
 rtl/xor_cipher.sv | 11 +
 rtl/uart_secure_rx.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_secure_rx_pkg.sv
// uart_secure_rx_pkg: shared key default, FSM state encoding and helpers
// for the secure UART receiver. KEY_VALUE may be overridden externally.
`ifndef KEY_VALUE
`define KEY_VALUE 8'hA5
`endif

package uart_secure_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  localparam logic [7:0] CNT_MAX = 8'hFF;

  function automatic logic [7:0] sat_inc8(
    input logic [7:0] v
  );
    return (v == CNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_secure_rx_if.sv
// uart_secure_rx_if: valid/ready byte stream out of the receiver.
// master: drives m_data/m_valid, takes m_ready; slave: the reverse.
interface uart_secure_rx_if #(
  parameter int DBIT = 8
);
  logic [DBIT-1:0] m_data;
  logic            m_valid;
  logic            m_ready;

  modport master (
    output m_data,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    output m_ready
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through FIFO, o_data is the head entry.
// Ports: clk, reset_n, i_push/i_data, i_pop, o_data, o_full, o_empty, o_drop.
module uart_rx_fifo
  import uart_secure_rx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_drop
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_pop;
  logic             w_do_push;

  // Extra pointer MSB tells full from empty.
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

  // A same-cycle pop frees the slot a full push needs.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_drop    = i_push && !w_do_push;

  assign o_data = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr[AW-1:0]] <= i_data;
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_do_pop)
        r_rptr <= r_rptr + 1'b1;
    end
  end
endmodule

// File: rtl/xor_cipher.sv
// xor_cipher: combinational XOR with a fixed key.
// Ports: i_data (WIDTH) in, o_data (WIDTH) = i_data ^ KEY.
module xor_cipher #(
  parameter int              WIDTH = 8,
  parameter logic [WIDTH-1:0] KEY  = '0
) (
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);
  assign o_data = i_data ^ KEY;
endmodule

// File: rtl/uart_secure_rx.sv
// uart_secure_rx: 8N1 oversampling receiver, XOR decrypt, FWFT output FIFO.
// Ports: clk, reset_n, s_tick, rx, m_if (master: m_data/m_valid/m_ready),
//  rx_busy, frame_err, overrun, cnt_clr, frame_err_cnt, overrun_cnt.
// Macro UART_RX_ERR_CNT_EN enables the saturating error counters.
module uart_secure_rx
  import uart_secure_rx_pkg::*;
#(
  parameter int              DBIT       = 8,
  parameter int              S_TICK     = 16,
  parameter int              SB_TICK    = 16,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [DBIT-1:0] KEY        = `KEY_VALUE
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    s_tick,
  input  logic                    rx,
  uart_secure_rx_if.master        m_if,
  output logic                    rx_busy,
  output logic                    frame_err,
  output logic                    overrun,
  input  logic                    cnt_clr,
  output logic [7:0]              frame_err_cnt,
  output logic [7:0]              overrun_cnt
);
  localparam int TMAX = (S_TICK > SB_TICK) ? S_TICK : SB_TICK;
  localparam int CW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int BW   = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [CW-1:0] C_HALF = CW'(S_TICK / 2 - 1);
  localparam logic [CW-1:0] C_BIT  = CW'(S_TICK - 1);
  localparam logic [CW-1:0] C_STOP = CW'(SB_TICK - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DBIT - 1);

  logic            r_sync1;
  logic            r_rx_s;
  rx_state_t       r_state;
  rx_state_t       w_state_n;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_n;
  logic [BW-1:0]   r_bit;
  logic [BW-1:0]   w_bit_n;
  logic [DBIT-1:0] r_sh;
  logic [DBIT-1:0] w_sh_n;
  logic            w_push;
  logic            w_ferr;
  logic [DBIT-1:0] w_plain;
  logic            w_empty;
  logic            w_full;
  logic            w_drop;
  logic            w_pop;
  logic            r_frame_err;
  logic            r_overrun;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_rx_s  <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_sh    <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_bit   <= w_bit_n;
      r_sh    <= w_sh_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_bit_n   = r_bit;
    w_sh_n    = r_sh;
    w_push    = 1'b0;
    w_ferr    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!r_rx_s) begin
          w_state_n = ST_START;
          w_cnt_n   = '0;
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (r_cnt == C_HALF) begin
            w_cnt_n = '0;
            if (!r_rx_s) begin
              w_state_n = ST_DATA;
              w_bit_n   = '0;
            end else begin
              w_state_n = ST_IDLE;
            end
          end else begin
            w_cnt_n = r_cnt + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (r_cnt == C_BIT) begin
            w_cnt_n = '0;
            w_sh_n  = {r_rx_s, r_sh[DBIT-1:1]};
            if (r_bit == B_LAST)
              w_state_n = ST_STOP;
            else
              w_bit_n = r_bit + 1'b1;
          end else begin
            w_cnt_n = r_cnt + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (s_tick) begin
          if (r_cnt == C_STOP) begin
            w_cnt_n = '0;
            if (r_rx_s) begin
              w_push    = 1'b1;
              w_state_n = ST_IDLE;
            end else begin
              w_ferr    = 1'b1;
              w_state_n = ST_BREAK;
            end
          end else begin
            w_cnt_n = r_cnt + 1'b1;
          end
        end
      end
      ST_BREAK: begin
        // Hold here so a stuck-low line reports once.
        if (r_rx_s)
          w_state_n = ST_IDLE;
      end
      default: begin
        w_state_n = ST_IDLE;
      end
    endcase
  end

  xor_cipher #(
    .WIDTH (DBIT),
    .KEY   (KEY)
  ) u_cipher (
    .i_data (r_sh),
    .o_data (w_plain)
  );

  assign w_pop = m_if.m_ready && !w_empty;

  uart_rx_fifo #(
    .WIDTH (DBIT),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_data  (w_plain),
    .i_pop   (w_pop),
    .o_data  (m_if.m_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_drop  (w_drop)
  );

  assign m_if.m_valid = !w_empty;
  assign rx_busy      = (r_state != ST_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_ferr;
      r_overrun   <= w_drop;
    end
  end

  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

`ifdef UART_RX_ERR_CNT_EN
  logic [7:0] r_ferr_cnt;
  logic [7:0] r_ovr_cnt;
  logic       w_unused_full;

  assign w_unused_full = w_full;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ferr_cnt <= '0;
      r_ovr_cnt  <= '0;
    end else if (cnt_clr) begin
      r_ferr_cnt <= '0;
      r_ovr_cnt  <= '0;
    end else begin
      if (r_frame_err)
        r_ferr_cnt <= sat_inc8(r_ferr_cnt);
      if (r_overrun)
        r_ovr_cnt <= sat_inc8(r_ovr_cnt);
    end
  end

  assign frame_err_cnt = r_ferr_cnt;
  assign overrun_cnt   = r_ovr_cnt;
`else
  logic w_unused_clr;

  assign w_unused_clr  = cnt_clr ^ w_full;
  assign frame_err_cnt = '0;
  assign overrun_cnt   = '0;
`endif
endmodule
